cost_acc_batch: RTL and testbench

Parametrised mean-squared-error cost accumulator for the training datapath. It accepts one vector of NUM output-layer deltas per handshake and squares the channels serially through a single saturating fixed-point multiplier. It sums half the squared error per sample into a batch accumulator and emits the batch-mean cost once every BATCH samples. It sits after the output-delta stage and feeds the training controller's cost/convergence monitor.

---
 rtl/cost_acc_batch_pkg.sv | 22 ++
 rtl/cost_acc_batch_mult_sat.sv | 33 +++
 rtl/cost_acc_batch.sv | 160 ++++++++++++++++
 tb/tb_cost_acc_batch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cost_acc_batch_pkg.sv
// Shared definitions for the MSE cost accumulator: default word format,
// FSM state encoding and an elaboration-time log2 helper.
package cost_acc_batch_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    ACC  = 2'd2
  } state_e;

  // Ceiling log2, used for counter widths and the batch-mean shift.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cost_acc_batch_mult_sat.sv
// Combinational signed fixed-point multiply, (a*b) >>> FRAC, clamped to the
// signed WIDTH range with an overflow flag.
module cost_acc_batch_mult_sat #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    ovf
);

  localparam logic signed [2*WIDTH-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] scaled;

  always_comb begin
    prod   = a * b;
    scaled = prod >>> FRAC;
    ovf    = 1'b0;
    p      = scaled[WIDTH-1:0];
    if (scaled > P_MAX) begin
      p   = P_MAX[WIDTH-1:0];
      ovf = 1'b1;
    end else if (scaled < P_MIN) begin
      p   = P_MIN[WIDTH-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/cost_acc_batch.sv
// Batch MSE cost accumulator: squares NUM deltas serially, sums half the
// squared error per sample and emits the batch mean every BATCH samples.
module cost_acc_batch
  import cost_acc_batch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int NUM   = 2,
  parameter int BATCH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 i_valid,
  input  logic [NUM*WIDTH-1:0] i_d,
  output logic                 o_ready,
  output logic [WIDTH-1:0]     o_cost,
  output logic                 o_valid,
  output logic                 o_sat
);

  localparam int K_W   = (NUM > 1) ? clog2(NUM) : 1;
  localparam int LOG2B = clog2(BATCH);
  localparam int CNT_W = (BATCH > 1) ? LOG2B : 1;

  localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

  state_e               state_q, state_d;
  logic [NUM*WIDTH-1:0] d_q, d_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     partial_q, partial_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     cost_q, cost_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;

  logic signed [WIDTH-1:0] ch;
  logic signed [WIDTH-1:0] sq;
  logic                    sq_ovf;
  logic [WIDTH:0]          part_add;
  logic [WIDTH:0]          acc_add;

  // Both operands are non-negative and below 2^(WIDTH-1), so the sum can only
  // overflow into the sign bit; result is {overflow, clamped_sum}.
  function automatic logic [WIDTH:0] add_pos(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[WIDTH-1]) return {1'b1, SAT_MAX};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  always_comb begin
    ch = '0;
    for (int i = 0; i < NUM; i++) begin
      if (k_q == K_W'(i)) ch = d_q[i*WIDTH +: WIDTH];
    end
  end

  cost_acc_batch_mult_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_sq (
    .a   (ch),
    .b   (ch),
    .p   (sq),
    .ovf (sq_ovf)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    partial_d = partial_q;
    acc_d     = acc_q;
    cost_d    = cost_q;
    valid_d   = 1'b0;
    sat_d     = sat_q;
    part_add  = add_pos(partial_q, sq);
    acc_add   = add_pos(acc_q, partial_q >> 1);

    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      partial_d = '0;
      acc_d     = '0;
      sat_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            d_d       = i_d;
            partial_d = '0;
            k_d       = '0;
            if (cnt_q == '0) sat_d = 1'b0;
            state_d   = SQR;
          end
        end
        SQR: begin
          partial_d = part_add[WIDTH-1:0];
          if (sq_ovf || part_add[WIDTH]) sat_d = 1'b1;
          if (k_q == K_LAST) state_d = ACC;
          else               k_d     = k_q + K_W'(1);
        end
        ACC: begin
          if (acc_add[WIDTH]) sat_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cost_d  = acc_add[WIDTH-1:0] >> LOG2B;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = acc_add[WIDTH-1:0];
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      partial_q <= '0;
      acc_q     <= '0;
      cost_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      acc_q     <= acc_d;
      cost_q    <= cost_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_cost  = cost_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_cost_acc_batch.sv
// Self-checking bench for cost_acc_batch: table-driven batches, randomized
// batches against an arithmetic reference model, and clr/rst corner cases.
module tb_cost_acc_batch;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam int NUM   = 2;
  localparam int BATCH = 4;
  localparam longint MAXV = 64'h7FFF_FFFF;

  localparam logic [31:0] HALF    = 32'h0080_0000;
  localparam logic [31:0] ONE     = 32'h0100_0000;
  localparam logic [31:0] NEG_ONE = 32'hFF00_0000;
  localparam logic [31:0] P127    = 32'h7F00_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clr;
  logic                 i_valid;
  logic [NUM*WIDTH-1:0] i_d;
  logic                 o_ready;
  logic [WIDTH-1:0]     o_cost;
  logic                 o_valid;
  logic                 o_sat;

  cost_acc_batch #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .NUM   (NUM),
    .BATCH (BATCH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .i_valid (i_valid),
    .i_d     (i_d),
    .o_ready (o_ready),
    .o_cost  (o_cost),
    .o_valid (o_valid),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] cost;
    logic        sat;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [31:0] qa [BATCH];
  logic [31:0] qb [BATCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic over the samples in qa/qb.
  function automatic void model_batch(output logic [31:0] cost, output logic sat);
    longint acc;
    longint part;
    longint sq;
    longint ch [NUM];
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < BATCH; i++) begin
      part  = 0;
      ch[0] = longint'($signed(qa[i]));
      ch[1] = longint'($signed(qb[i]));
      for (int c = 0; c < NUM; c++) begin
        sq = (ch[c] * ch[c]) >>> FRAC;
        if (sq > MAXV) begin sq = MAXV; sat = 1'b1; end
        part = part + sq;
        if (part > MAXV) begin part = MAXV; sat = 1'b1; end
      end
      acc = acc + part / 2;
      if (acc > MAXV) begin acc = MAXV; sat = 1'b1; end
    end
    cost = 32'(acc / BATCH);
  endfunction

  function automatic logic [31:0] rnd_delta();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
  endfunction

  // Holds i_valid high until n samples from qa/qb are accepted, then idles
  // long enough to catch any resulting o_valid. Starts and ends on a negedge.
  task automatic stream(input int n, input bit want_pulse, input logic [31:0] exp_cost,
                        input logic exp_sat, input string tag);
    int accepted = 0;
    int busy = 0;
    int tail = 0;
    int guard = 0;
    int ready_err = 0;
    int gap_err = 0;
    int last_acc = -1;
    int npulse = 0;
    int pulse_edge = -1;
    logic [31:0] pcost = '0;
    logic psat = 1'b0;
    logic will;
    forever begin
      if (o_valid === 1'b1) begin
        npulse++;
        pulse_edge = cyc;
        pcost = o_cost;
        psat = o_sat;
      end
      if (o_ready !== (busy == 0)) ready_err++;
      if (accepted == n && tail >= NUM + 3) break;
      if (guard >= 50 * BATCH) begin
        total++;
        $display("FAIL %s_timeout: accepted %0d of %0d samples", tag, accepted, n);
        break;
      end
      if (accepted < n) begin
        i_valid = 1'b1;
        i_d = {qb[accepted], qa[accepted]};
      end else begin
        i_valid = 1'b0;
      end
      will = i_valid && o_ready;
      @(posedge clk);
      cyc++;
      guard++;
      if (accepted == n) tail++;
      if (will) begin
        if (last_acc >= 0 && cyc - last_acc != NUM + 2) gap_err++;
        last_acc = cyc;
        accepted++;
        busy = NUM + 1;
      end else if (busy > 0) begin
        busy--;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    check({tag, "_ready_pattern_errs"}, 32'(ready_err), 32'd0);
    check({tag, "_accept_gap_errs"}, 32'(gap_err), 32'd0);
    if (want_pulse) begin
      check({tag, "_pulse_count"}, 32'(npulse), 32'd1);
      check({tag, "_pulse_latency"}, 32'(pulse_edge - last_acc), 32'(NUM + 1));
      check({tag, "_cost"}, pcost, exp_cost);
      check({tag, "_sat"}, 32'(psat), 32'(exp_sat));
    end else begin
      check({tag, "_pulse_count"}, 32'(npulse), 32'd0);
    end
  endtask

  initial begin
    vec_t tbl [3];
    logic [31:0] ec;
    logic es;
    int stray;

    tbl[0] = '{a: HALF,    b: HALF,  cost: 32'h0040_0000, sat: 1'b0};
    tbl[1] = '{a: NEG_ONE, b: 32'd0, cost: 32'h0080_0000, sat: 1'b0};
    tbl[2] = '{a: P127,    b: 32'd0, cost: 32'h1FFF_FFFF, sat: 1'b1};

    rst = 1'b1;
    clr = 1'b0;
    i_valid = 1'b0;
    i_d = '0;
    repeat (2) @(negedge clk);
    check("reset_cost", o_cost, 32'd0);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_sat", 32'(o_sat), 32'd0);
    check("reset_ready", 32'(o_ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(o_ready), 32'd1);
    check("idle_valid", 32'(o_valid), 32'd0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < BATCH; i++) begin
        qa[i] = tbl[t].a;
        qb[i] = tbl[t].b;
      end
      stream(BATCH, 1'b1, tbl[t].cost, tbl[t].sat, $sformatf("tbl%0d", t));
    end

    // Sticky o_sat survives idle time and clears on the next batch's first accept.
    check("sat_sticky_idle", 32'(o_sat), 32'd1);
    qa[0] = HALF;
    qb[0] = HALF;
    stream(1, 1'b0, '0, 1'b0, "sat_clear");
    check("sat_cleared", 32'(o_sat), 32'd0);

    // clr with i_valid: sample not accepted, batch state dropped, cost kept.
    clr = 1'b1;
    i_valid = 1'b1;
    i_d = {HALF, HALF};
    @(negedge clk);
    clr = 1'b0;
    i_valid = 1'b0;
    check("clr_no_accept_ready", 32'(o_ready), 32'd1);
    check("clr_keeps_cost", o_cost, 32'h1FFF_FFFF);

    for (int i = 0; i < BATCH; i++) begin
      qa[i] = HALF;
      qb[i] = HALF;
    end
    stream(2, 1'b0, '0, 1'b0, "pre_clr");
    i_valid = 1'b1;
    i_d = {HALF, HALF};
    check("third_accept_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    check("third_busy", 32'(o_ready), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_mid_sqr_idle", 32'(o_ready), 32'd1);
    check("clr_mid_sqr_valid", 32'(o_valid), 32'd0);
    check("clr_mid_sqr_cost", o_cost, 32'h1FFF_FFFF);
    stream(BATCH, 1'b1, 32'h0040_0000, 1'b0, "post_clr");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < BATCH; i++) begin
        qa[i] = rnd_delta();
        qb[i] = rnd_delta();
      end
      model_batch(ec, es);
      stream(BATCH, 1'b1, ec, es, $sformatf("rand%0d", r));
    end

    // Reset during ACC of the last sample of a saturating batch.
    for (int i = 0; i < BATCH; i++) begin
      qa[i] = P127;
      qb[i] = ONE;
    end
    stream(BATCH - 1, 1'b0, '0, 1'b0, "pre_rst");
    i_valid = 1'b1;
    i_d = {qb[0], qa[0]};
    @(negedge clk);
    i_valid = 1'b0;
    repeat (NUM) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_acc_cost", o_cost, 32'd0);
    check("rst_acc_valid", 32'(o_valid), 32'd0);
    check("rst_acc_sat", 32'(o_sat), 32'd0);
    check("rst_acc_ready", 32'(o_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < NUM + 3; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) stray++;
      if (i == 1) rst = 1'b0;
    end
    check("rst_acc_no_pulse", 32'(stray), 32'd0);
    for (int i = 0; i < BATCH; i++) begin
      qa[i] = HALF;
      qb[i] = HALF;
    end
    stream(BATCH, 1'b1, 32'h0040_0000, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
